// File: rtl/requant_out_packer.sv
// Adds the output zero point to the serial int8 requant stream with saturation, packs the
// bytes into SRAM words and writes them through a small FIFO that absorbs write-port stalls.
module requant_out_packer #(
    parameter int DATA_WIDTH  = 8,
    parameter int SRAM_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 13,
    parameter int COUNT_WIDTH = 18,
    parameter int FIFO_DEPTH  = 4,
    localparam int LANES      = SRAM_WIDTH / DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [COUNT_WIDTH-1:0]       total_count,
    input  logic signed [DATA_WIDTH-1:0] zero_point,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         sram_wr_ready,
    output logic                         sram_wr_en,
    output logic [ADDR_WIDTH-1:0]        sram_wr_addr,
    output logic [SRAM_WIDTH-1:0]        sram_wr_data,
    output logic [LANES-1:0]             sram_wr_strb,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow_err
);

    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                  state;
    logic [COUNT_WIDTH-1:0]      total_q;
    logic [COUNT_WIDTH-1:0]      elem_cnt;
    logic [DATA_WIDTH-1:0]       zp_q;
    logic [LANE_W-1:0]           lane_cnt;
    logic [SRAM_WIDTH-1:0]       acc;
    logic [LANES-1:0]            strb_acc;
    logic [ADDR_WIDTH-1:0]       wr_addr;

    logic [SRAM_WIDTH-1:0]       fifo_data [FIFO_DEPTH];
    logic [LANES-1:0]            fifo_strb [FIFO_DEPTH];
    logic [PTR_W:0]              wr_ptr;
    logic [PTR_W:0]              rd_ptr;

    logic                        start_ok;
    logic                        accept;
    logic                        last_elem;
    logic                        push;
    logic                        push_ok;
    logic                        pop;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [DATA_WIDTH:0]         sum;
    logic [DATA_WIDTH-1:0]       sat;
    logic [SRAM_WIDTH-1:0]       word_next;
    logic [LANES-1:0]            strb_next;

    assign start_ok   = start && (state == IDLE);
    assign accept     = in_valid && (state == RUN);
    assign last_elem  = (elem_cnt == total_q - COUNT_WIDTH'(1));
    assign push       = accept && ((lane_cnt == LANE_W'(LANES - 1)) || last_elem);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = !fifo_empty && sram_wr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push && (!fifo_full || pop);

    // Sum at one extra bit, then clamp when the two top bits disagree.
    always_comb begin
        sum = {zp_q[DATA_WIDTH-1], zp_q} + {in_data[DATA_WIDTH-1], in_data};
        sat = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            sat = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                  : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        word_next = acc;
        strb_next = strb_acc;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                word_next[k*DATA_WIDTH +: DATA_WIDTH] = sat;
                strb_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            total_q      <= '0;
            zp_q         <= '0;
            elem_cnt     <= '0;
            lane_cnt     <= '0;
            acc          <= '0;
            strb_acc     <= '0;
            wr_addr      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start) state <= (total_count == '0) ? DONE : RUN;
                RUN:     if (accept && last_elem) state <= DRAIN;
                DRAIN:   if (fifo_empty) state <= DONE;
                default: state <= IDLE;
            endcase

            if (start_ok) begin
                total_q      <= total_count;
                zp_q         <= zero_point;
                elem_cnt     <= '0;
                lane_cnt     <= '0;
                acc          <= '0;
                strb_acc     <= '0;
                wr_addr      <= base_addr;
                overflow_err <= 1'b0;
            end else begin
                if (accept) begin
                    elem_cnt <= elem_cnt + COUNT_WIDTH'(1);
                    lane_cnt <= push ? '0 : lane_cnt + LANE_W'(1);
                    acc      <= push ? '0 : word_next;
                    strb_acc <= push ? '0 : strb_next;
                end
                if (pop) wr_addr <= wr_addr + ADDR_WIDTH'(1);
                if (push && fifo_full && !pop) overflow_err <= 1'b1;
            end

            if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr[PTR_W-1:0]] <= word_next;
            fifo_strb[wr_ptr[PTR_W-1:0]] <= strb_next;
        end
    end

    // Head data is gated so the outputs read zero whenever nothing is queued.
    assign sram_wr_en   = !fifo_empty;
    assign sram_wr_addr = wr_addr;
    assign sram_wr_data = sram_wr_en ? fifo_data[rd_ptr[PTR_W-1:0]] : '0;
    assign sram_wr_strb = sram_wr_en ? fifo_strb[rd_ptr[PTR_W-1:0]] : '0;
    assign busy         = (state == RUN) || (state == DRAIN);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_requant_out_packer.sv
// Directed bench for requant_out_packer: packing, saturation, partial words, FIFO overflow,
// address wrap, zero-length runs and mid-run reset.
module tb_requant_out_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [12:0] base_addr = '0;
    logic [17:0] total_count = '0;
    logic [7:0]  zero_point = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        sram_wr_ready = 1'b1;
    logic        sram_wr_en;
    logic [12:0] sram_wr_addr;
    logic [63:0] sram_wr_data;
    logic [7:0]  sram_wr_strb;
    logic        busy;
    logic        done;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_cyc = 0;
    int start_cyc = 0;
    int done_base = 0;

    logic [12:0] addr_q [$];
    logic [63:0] data_q [$];
    logic [7:0]  strb_q [$];
    logic [7:0]  stim_q [$];

    requant_out_packer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .total_count   (total_count),
        .zero_point    (zero_point),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .sram_wr_ready (sram_wr_ready),
        .sram_wr_en    (sram_wr_en),
        .sram_wr_addr  (sram_wr_addr),
        .sram_wr_data  (sram_wr_data),
        .sram_wr_strb  (sram_wr_strb),
        .busy          (busy),
        .done          (done),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after the rising edge, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (sram_wr_en && sram_wr_ready) begin
            addr_q.push_back(sram_wr_addr);
            data_q.push_back(sram_wr_data);
            strb_q.push_back(sram_wr_strb);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic startRun(input logic [12:0] base, input logic [17:0] total, input logic [7:0] zp);
        base_addr   = base;
        total_count = total;
        zero_point  = zp;
        start       = 1'b1;
        start_cyc   = cyc;
        done_base   = done_cnt;
        tick(1);
        start = 1'b0;
    endtask

    task automatic applyStimulus();
        foreach (stim_q[i]) begin
            in_valid = 1'b1;
            in_data  = stim_q[i];
            last_cyc = cyc;
            tick(1);
        end
        in_valid = 1'b0;
        stim_q.delete();
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 300 && done_cnt == done_base; i++) tick(1);
        tick(3);
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
    endtask

    task automatic checkWrite(input string tag, input logic [12:0] addr, input logic [63:0] data, input logic [7:0] strb);
        if (addr_q.size() == 0) begin
            checkOutput({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, "_addr"}, 64'(addr_q.pop_front()), 64'(addr));
            checkOutput({tag, "_data"}, data_q.pop_front(), data);
            checkOutput({tag, "_strb"}, 64'(strb_q.pop_front()), 64'(strb));
        end
    endtask

    task automatic clearLog();
        addr_q.delete();
        data_q.delete();
        strb_q.delete();
    endtask

    initial begin
        logic [63:0] word;

        tick(3);
        checkOutput("rst_wr_en", 64'(sram_wr_en), 64'd0);
        checkOutput("rst_outputs", {sram_wr_addr, sram_wr_strb, busy, done, overflow_err}, 64'd0);
        checkOutput("rst_data", sram_wr_data, 64'd0);
        rst = 1'b1;
        tick(2);

        // Two full words, back-to-back elements, ready always high.
        startRun(13'h100, 18'd16, 8'd0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(i));
        applyStimulus();
        waitDone("t1");
        checkOutput("t1_latency", 64'(done_cyc - last_cyc), 64'd3);
        checkOutput("t1_writes", 64'(addr_q.size()), 64'd2);
        checkWrite("t1_w0", 13'h100, 64'h0706050403020100, 8'hFF);
        checkWrite("t1_w1", 13'h101, 64'h0F0E0D0C0B0A0908, 8'hFF);

        // Saturation at both ends: 120+10, -5+10, -128+10, then -125-10.
        clearLog();
        startRun(13'h200, 18'd3, 8'd10);
        stim_q = '{8'd120, 8'hFB, 8'h80};
        applyStimulus();
        waitDone("t2a");
        checkWrite("t2a_w0", 13'h200, 64'h0000_0000_008A_057F, 8'h07);
        startRun(13'h210, 18'd1, 8'hF6);
        stim_q = '{8'h83};
        applyStimulus();
        waitDone("t2b");
        checkWrite("t2b_w0", 13'h210, 64'h0000_0000_0000_0080, 8'h01);

        // Partial final word; the surplus 12th element must be dropped.
        clearLog();
        startRun(13'h300, 18'd11, 8'd0);
        for (int i = 1; i <= 12; i++) stim_q.push_back(8'(i));
        applyStimulus();
        waitDone("t3");
        checkOutput("t3_writes", 64'(addr_q.size()), 64'd2);
        checkWrite("t3_w0", 13'h300, 64'h0807060504030201, 8'hFF);
        checkWrite("t3_w1", 13'h301, 64'h0000_0000_000B_0A09, 8'h07);

        // Stalled write port: FIFO holds four words, the rest are dropped.
        clearLog();
        sram_wr_ready = 1'b0;
        startRun(13'h010, 18'd64, 8'd0);
        for (int i = 0; i < 64; i++) stim_q.push_back(8'(i));
        applyStimulus();
        tick(2);
        checkOutput("t4_overflow", 64'(overflow_err), 64'd1);
        checkOutput("t4_stall_en", 64'(sram_wr_en), 64'd1);
        checkOutput("t4_stall_addr", 64'(sram_wr_addr), 64'h010);
        checkOutput("t4_stall_data", sram_wr_data, 64'h0706050403020100);
        tick(1);
        checkOutput("t4_stall_hold", sram_wr_data, 64'h0706050403020100);
        sram_wr_ready = 1'b1;
        waitDone("t4");
        checkOutput("t4_writes", 64'(addr_q.size()), 64'd4);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 8; k++) word[k*8 +: 8] = 8'(8*w + k);
            checkWrite($sformatf("t4_w%0d", w), 13'(13'h010 + w), word, 8'hFF);
        end
        checkOutput("t4_overflow_sticky", 64'(overflow_err), 64'd1);

        // Address wrap, then a zero-length run.
        clearLog();
        startRun(13'h1FFF, 18'd16, 8'd0);
        checkOutput("t5_overflow_cleared", 64'(overflow_err), 64'd0);
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(i));
        applyStimulus();
        waitDone("t5a");
        checkWrite("t5_w0", 13'h1FFF, 64'h0706050403020100, 8'hFF);
        checkWrite("t5_w1", 13'h0000, 64'h0F0E0D0C0B0A0908, 8'hFF);
        startRun(13'h0500, 18'd0, 8'd0);
        waitDone("t5b");
        checkOutput("t5b_latency", 64'(done_cyc - start_cyc), 64'd1);
        checkOutput("t5b_writes", 64'(addr_q.size()), 64'd0);

        // Reset in the middle of a stalled run, then a clean restart.
        clearLog();
        sram_wr_ready = 1'b0;
        startRun(13'h040, 18'd16, 8'd0);
        for (int i = 0; i < 10; i++) stim_q.push_back(8'(8'h50 + i));
        applyStimulus();
        checkOutput("t6_pre_en", 64'(sram_wr_en), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_wr_en", 64'(sram_wr_en), 64'd0);
        checkOutput("t6_rst_outputs", {sram_wr_addr, sram_wr_strb, busy, done, overflow_err}, 64'd0);
        checkOutput("t6_rst_data", sram_wr_data, 64'd0);
        sram_wr_ready = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(5);
        checkOutput("t6_no_writes", 64'(addr_q.size()), 64'd0);
        startRun(13'h020, 18'd8, 8'd0);
        for (int i = 0; i < 8; i++) stim_q.push_back(8'(8'hA0 + i));
        applyStimulus();
        waitDone("t6");
        checkOutput("t6_writes", 64'(addr_q.size()), 64'd1);
        checkWrite("t6_w0", 13'h020, 64'hA7A6A5A4A3A2A1A0, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
